// File: rtl/lcd_hd44780_pkg.sv
// lcd_hd44780_pkg: shared types, opcode masks and address helpers for the
// HD44780-style bus responder. Constants only needed by the optional init
// sequencing check are present when LCD_INIT_CHECK_EN is defined.
package lcd_hd44780_pkg;

   typedef enum logic [1:0] {S_IDLE, S_EHI, S_EXEC} state_e;

   // Instruction class masks; the highest set bit selects the instruction.
   localparam logic [7:0] OP_CLEAR_M = 8'h01;
   localparam logic [7:0] OP_HOME_M  = 8'h02;
   localparam logic [7:0] OP_ENTRY_M = 8'h04;
   localparam logic [7:0] OP_DISP_M  = 8'h08;
   localparam logic [7:0] OP_SHIFT_M = 8'h10;
   localparam logic [7:0] OP_FUNC_M  = 8'h20;
   localparam logic [7:0] OP_CGRAM_M = 8'h40;
   localparam logic [7:0] OP_DDRAM_M = 8'h80;
`ifdef LCD_INIT_CHECK_EN
   localparam logic [7:0] FUNC_SET_8BIT = 8'h38;
   localparam logic [7:0] FUNC_DL_M     = 8'h10;
`endif

   localparam logic [6:0] ROW0_BASE  = 7'h00;
   localparam logic [6:0] ROW1_BASE  = 7'h40;
   localparam int         ROW_LEN    = 16;
   localparam int         CELLS      = 2 * ROW_LEN;
   localparam logic [7:0] BLANK_CHAR = 8'h20;

   // Map an address counter value onto a linear cell index (row bit + column).
   function automatic logic [4:0] cell_idx(input logic [6:0] ac);
      return {ac[6], ac[3:0]};
   endfunction

   // Advance the address counter by one column, wrapping between the rows.
   function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
      logic [3:0] col;
      col = ac[3:0];
      if (inc) begin
         if (col == 4'(ROW_LEN - 1)) return ac[6] ? ROW0_BASE : ROW1_BASE;
         return {ac[6], 2'b00, col + 4'd1};
      end
      if (col == 4'd0) return ac[6] ? ROW0_BASE + 7'(ROW_LEN - 1) : ROW1_BASE + 7'(ROW_LEN - 1);
      return {ac[6], 2'b00, col - 4'd1};
   endfunction

endpackage

// File: rtl/lcd_ddram_store.sv
// lcd_ddram_store: 32x8 display image with single-cycle clear, one write
// port, a combinational port at the address counter and a registered debug port.
module lcd_ddram_store
   import lcd_hd44780_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr_i,
   input  logic       we_i,
   input  logic [4:0] waddr_i,
   input  logic [7:0] wdata_i,
   input  logic [4:0] cur_addr_i,
   output logic [7:0] cur_data_o,
   input  logic [4:0] rd_addr_i,
   output logic [7:0] rd_data_o
);

   logic [7:0] mem_q [CELLS];
   logic [7:0] rd_q;

   // Cell array: reset and clear both blank every cell, otherwise one write per cycle.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the array is reset explicitly because the image must read blank straight
      // out of reset; that keeps it in flops rather than a RAM macro.
      if (rst) begin
         for (int i = 0; i < CELLS; i++) mem_q[i] <= BLANK_CHAR;
      end else if (clr_i) begin
         for (int i = 0; i < CELLS; i++) mem_q[i] <= BLANK_CHAR;
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Debug read port, one cycle of latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_q <= 8'h00;
      else     rd_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o  = rd_q;
   assign cur_data_o = mem_q[cur_addr_i];

endmodule

// File: rtl/lcd_hd44780_responder.sv
// lcd_hd44780_responder: captures HD44780-style 8-bit bus transactions on the
// falling edge of E and keeps a 2x16 DDRAM image, address counter and busy flag.
// Build macro LCD_INIT_CHECK_EN: DDRAM access before function set 0x38, and any
// 4-bit function set, are flagged on o_err.
module lcd_hd44780_responder
   import lcd_hd44780_pkg::*;
#(
   parameter int BUSY_CYCLES       = 3700,
   parameter int BUSY_CLEAR_CYCLES = 152000,
   parameter int MIN_E_CYCLES      = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       lcd_e,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic [7:0] lcd_data,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_char,
   output logic [7:0] o_rdata,
   output logic [6:0] o_ac,
   output logic       o_busy,
   output logic       o_disp_on,
   output logic       o_wr_strobe,
   output logic       o_err
);

   localparam int BUSY_MAX = (BUSY_CLEAR_CYCLES > BUSY_CYCLES) ? BUSY_CLEAR_CYCLES : BUSY_CYCLES;
   localparam int BW = $clog2(BUSY_MAX + 1);
   localparam int WW = $clog2(MIN_E_CYCLES + 1);
   localparam logic [BW-1:0] BUSY_LD  = BW'(BUSY_CYCLES);
   localparam logic [BW-1:0] CLEAR_LD = BW'(BUSY_CLEAR_CYCLES);
   localparam logic [WW-1:0] MIN_E    = WW'(MIN_E_CYCLES);

   logic [10:0]   sync1_q, sync2_q;
   logic          e_s, rs_s, rw_s;
   logic [7:0]    data_s;
   state_e        state_q, state_d;
   logic [WW-1:0] width_q, width_d;
   logic          rs_q, rs_d, rw_q, rw_d, inc_q, inc_d;
   logic [7:0]    data_q, data_d, rdata_q, rdata_d;
   logic [6:0]    ac_q, ac_d;
   logic [BW-1:0] busy_cnt_q, busy_cnt_d;
   logic          disp_on_q, disp_on_d, err_q, err_d, wr_strobe_q, wr_strobe_d;
   logic          busy, mem_we, mem_clr, init_block;
   logic [7:0]    cur_char;

   assign {e_s, rs_s, rw_s, data_s} = sync2_q;
   assign busy = (busy_cnt_q != '0);

`ifdef LCD_INIT_CHECK_EN
   logic init_done_q, init_done_d;
   assign init_block = !init_done_q && (rs_q || ((data_q & OP_DDRAM_M) != 8'h00));
`else
   assign init_block = 1'b0;
`endif

   // Two-flop stage on all bus inputs so E, RS, RW and data stay aligned.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {lcd_e, lcd_rs, lcd_rw, lcd_data};
         sync2_q <= sync1_q;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // FSM next state: wait for E, measure its width, execute once on acceptance.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (e_s) state_d = S_EHI;
         S_EHI:   if (!e_s) state_d = (width_q < MIN_E) ? S_IDLE : S_EXEC;
         S_EXEC:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: edge capture, width counting and the single-cycle execute.
   always_comb begin
      // NOTE: every signal gets a default first so no latches are inferred.
      width_d     = width_q;
      rs_d        = rs_q;
      rw_d        = rw_q;
      data_d      = data_q;
      ac_d        = ac_q;
      inc_d       = inc_q;
      disp_on_d   = disp_on_q;
      err_d       = err_q;
      rdata_d     = rdata_q;
      wr_strobe_d = 1'b0;
      mem_we      = 1'b0;
      mem_clr     = 1'b0;
      busy_cnt_d  = busy ? busy_cnt_q - BW'(1) : busy_cnt_q;
`ifdef LCD_INIT_CHECK_EN
      init_done_d = init_done_q;
`endif
      case (state_q)
         S_IDLE: if (e_s) width_d = '0;
         S_EHI: begin
            if (e_s) begin
               if (width_q < MIN_E) width_d = width_q + WW'(1);
            end else begin
               rs_d   = rs_s;
               rw_d   = rw_s;
               data_d = data_s;
               if (width_q < MIN_E) err_d = 1'b1;
            end
         end
         S_EXEC: begin
            if (rw_q) begin
               // Reads are served regardless of busy and never reload it.
               if (rs_q) begin
                  rdata_d = cur_char;
                  ac_d    = ac_step(ac_q, inc_q);
               end else begin
                  rdata_d = {busy, ac_q};
               end
            end else if (busy || init_block) begin
               err_d = 1'b1;
            end else begin
               busy_cnt_d = BUSY_LD;
               if (rs_q) begin
                  mem_we      = 1'b1;
                  wr_strobe_d = 1'b1;
                  ac_d        = ac_step(ac_q, inc_q);
               end else if ((data_q & OP_DDRAM_M) != 8'h00) begin
                  ac_d = {data_q[6], 2'b00, data_q[3:0]};
                  if (data_q[5:4] != 2'b00) err_d = 1'b1;
               end else if ((data_q & OP_CGRAM_M) != 8'h00) begin
                  // CGRAM is not modelled; only the busy time applies.
               end else if ((data_q & OP_FUNC_M) != 8'h00) begin
`ifdef LCD_INIT_CHECK_EN
                  if (data_q == FUNC_SET_8BIT) init_done_d = 1'b1;
                  if ((data_q & FUNC_DL_M) == 8'h00) err_d = 1'b1;
`endif
               end else if ((data_q & OP_SHIFT_M) != 8'h00) begin
                  // Cursor/display shift is not modelled; only the busy time applies.
               end else if ((data_q & OP_DISP_M) != 8'h00) begin
                  disp_on_d = data_q[2];
               end else if ((data_q & OP_ENTRY_M) != 8'h00) begin
                  inc_d = data_q[1];
               end else if ((data_q & OP_HOME_M) != 8'h00) begin
                  ac_d       = ROW0_BASE;
                  busy_cnt_d = CLEAR_LD;
               end else if ((data_q & OP_CLEAR_M) != 8'h00) begin
                  mem_clr    = 1'b1;
                  ac_d       = ROW0_BASE;
                  inc_d      = 1'b1;
                  busy_cnt_d = CLEAR_LD;
               end
            end
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         width_q     <= '0;
         rs_q        <= 1'b0;
         rw_q        <= 1'b0;
         data_q      <= 8'h00;
         ac_q        <= ROW0_BASE;
         inc_q       <= 1'b1;
         busy_cnt_q  <= '0;
         disp_on_q   <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= 8'h00;
         wr_strobe_q <= 1'b0;
      end else begin
         width_q     <= width_d;
         rs_q        <= rs_d;
         rw_q        <= rw_d;
         data_q      <= data_d;
         ac_q        <= ac_d;
         inc_q       <= inc_d;
         busy_cnt_q  <= busy_cnt_d;
         disp_on_q   <= disp_on_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         wr_strobe_q <= wr_strobe_d;
      end
   end

`ifdef LCD_INIT_CHECK_EN
   // Remembers that the 8-bit function set has been seen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) init_done_q <= 1'b0;
      else     init_done_q <= init_done_d;
   end
`endif

   lcd_ddram_store u_store (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (mem_clr),
      .we_i       (mem_we),
      .waddr_i    (cell_idx(ac_q)),
      .wdata_i    (data_q),
      .cur_addr_i (cell_idx(ac_q)),
      .cur_data_o (cur_char),
      .rd_addr_i  (rd_addr),
      .rd_data_o  (rd_char)
   );

   assign o_rdata     = rdata_q;
   assign o_ac        = ac_q;
   assign o_busy      = busy;
   assign o_disp_on   = disp_on_q;
   assign o_wr_strobe = wr_strobe_q;
   assign o_err       = err_q;

endmodule
